// File: rtl/cmp_cal_seq.sv
// cmp_cal_seq: calibrates comparator offsets one channel at a time.
// Each channel is cleared, given time to settle, and then measured over a
// window of CAL_SAMPLES cycles. A 1-LSB trim step is applied after each
// window until the ones count is close to half the window. The search also
// stops when the error changes sign or grows, or when a trim code saturates.
// Optional feature macro: CMP_CAL_SAT_FLAGS_EN adds the per-channel `sat`
// flag port.
module cmp_cal_seq #(
  parameter int N_CMP        = 8,
  parameter int TRIM_W       = 5,
  parameter int CAL_SAMPLES  = 250,
  parameter int ALLOWED_DIFF = 10,
  parameter int SETTLE       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [N_CMP-1:0]          cmp_out,
  output logic [N_CMP*TRIM_W-1:0]   b_left,
  output logic [N_CMP*TRIM_W-1:0]   b_right,
  output logic                      busy,
`ifdef CMP_CAL_SAT_FLAGS_EN
  output logic [N_CMP-1:0]          sat,
`endif
  output logic                      done
);

  localparam int ONES_W = $clog2(CAL_SAMPLES + 1);
  localparam int CNT_W  = $clog2(CAL_SAMPLES + SETTLE + 1);
  localparam int CH_W   = (N_CMP > 1) ? $clog2(N_CMP) : 1;

  localparam logic signed [ONES_W:0] HALF_S      = (ONES_W+1)'(CAL_SAMPLES / 2);
  localparam logic [ONES_W:0]        TOL         = (ONES_W+1)'(ALLOWED_DIFF);
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]       MEAS_LAST   = CNT_W'(CAL_SAMPLES - 1);
  localparam logic [CH_W-1:0]        CH_LAST     = CH_W'(N_CMP - 1);
  localparam logic [TRIM_W-1:0]      TRIM_MAX    = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_SETTLE, ST_MEASURE, ST_EVAL, ST_NEXT, ST_DONE
  } state_t;

  typedef enum logic [1:0] {ACT_LOCK, ACT_UNDO, ACT_STEP} act_t;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ONES_W-1:0]        ones_q;
  logic signed [ONES_W:0]   last_diff_q;
  logic                     first_q;
  logic                     last_left_q;
  logic                     last_inc_q;

  logic [TRIM_W-1:0]        cur_l, cur_r, step_code;
  logic signed [ONES_W:0]   diff;
  logic [ONES_W:0]          abs_diff, abs_last;
  logic                     step_left, step_inc, sat_hit;
  act_t                     act;

  // Decide the outcome of the window just measured for the current channel
  always_comb begin
    cur_l     = b_left[ch_q*TRIM_W +: TRIM_W];
    cur_r     = b_right[ch_q*TRIM_W +: TRIM_W];
    diff      = $signed({1'b0, ones_q}) - HALF_S;
    abs_diff  = diff[ONES_W] ? $unsigned(-diff) : $unsigned(diff);
    abs_last  = last_diff_q[ONES_W] ? $unsigned(-last_diff_q) : $unsigned(last_diff_q);
    step_left = (!diff[ONES_W] && cur_r == '0) || (diff[ONES_W] && cur_l != '0);
    step_inc  = (!diff[ONES_W] && cur_r == '0) || (diff[ONES_W] && cur_l == '0);
    step_code = step_left ? cur_l : cur_r;
    sat_hit   = step_inc && (step_code == TRIM_MAX);
    act       = ACT_STEP;
    if (abs_diff <= TOL)
      act = ACT_LOCK;
    else if (!first_q && abs_diff > abs_last)
      act = ACT_UNDO;
    else if (!first_q && (diff[ONES_W] != last_diff_q[ONES_W]))
      act = ACT_LOCK;
  end

  // Next-state selection and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = ST_MEASURE;
      ST_MEASURE: if (cnt_q == MEAS_LAST) state_d = ST_EVAL;
      ST_EVAL:    state_d = (act == ACT_STEP && !sat_hit) ? ST_SETTLE : ST_NEXT;
      ST_NEXT:    state_d = (ch_q == CH_LAST) ? ST_DONE : ST_CLEAR;
      ST_DONE:    if (start) state_d = ST_CLEAR;
      default:    state_d = ST_IDLE;
    endcase
    if (!en)
      state_d = ST_IDLE;
    busy = (state_q == ST_CLEAR) || (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
           (state_q == ST_EVAL) || (state_q == ST_NEXT);
    done = (state_q == ST_DONE);
  end

  // State register plus channel, counter and trim datapath updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      last_diff_q <= '0;
      first_q     <= 1'b1;
      last_left_q <= 1'b0;
      last_inc_q  <= 1'b0;
      b_left      <= '0;
      b_right     <= '0;
`ifdef CMP_CAL_SAT_FLAGS_EN
      sat         <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (!en) begin
        cnt_q  <= '0;
        ones_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              ch_q <= '0;
`ifdef CMP_CAL_SAT_FLAGS_EN
              sat  <= '0;
`endif
            end
          end
          ST_CLEAR: begin
            b_left[ch_q*TRIM_W +: TRIM_W]  <= '0;
            b_right[ch_q*TRIM_W +: TRIM_W] <= '0;
            first_q <= 1'b1;
            cnt_q   <= '0;
            ones_q  <= '0;
          end
          ST_SETTLE: begin
            cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
          end
          ST_MEASURE: begin
            ones_q <= ones_q + ONES_W'(cmp_out[ch_q]);
            cnt_q  <= (cnt_q == MEAS_LAST) ? '0 : cnt_q + 1'b1;
          end
          ST_EVAL: begin
            ones_q <= '0;
            cnt_q  <= '0;
            if (act == ACT_UNDO) begin
              if (last_left_q)
                b_left[ch_q*TRIM_W +: TRIM_W] <= last_inc_q ? cur_l - 1'b1 : cur_l + 1'b1;
              else
                b_right[ch_q*TRIM_W +: TRIM_W] <= last_inc_q ? cur_r - 1'b1 : cur_r + 1'b1;
            end else if (act == ACT_STEP) begin
              if (sat_hit) begin
`ifdef CMP_CAL_SAT_FLAGS_EN
                sat[ch_q] <= 1'b1;
`endif
              end else begin
                if (step_left)
                  b_left[ch_q*TRIM_W +: TRIM_W] <= step_inc ? cur_l + 1'b1 : cur_l - 1'b1;
                else
                  b_right[ch_q*TRIM_W +: TRIM_W] <= step_inc ? cur_r + 1'b1 : cur_r - 1'b1;
                last_diff_q <= diff;
                first_q     <= 1'b0;
                last_left_q <= step_left;
                last_inc_q  <= step_inc;
              end
            end
          end
          ST_NEXT: begin
            if (ch_q != CH_LAST)
              ch_q <= ch_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmp_cal_seq.sv
// tb_cmp_cal_seq: directed bench for cmp_cal_seq with a closed-loop
// comparator plant whose ones count is a linear function of the trims.
module tb_cmp_cal_seq;

  localparam int N  = 8;
  localparam int TW = 5;

  typedef struct {
    int base;
    int slope;
    int exp_bl;
    int exp_br;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic              start;
  logic [N-1:0]      cmp_out;
  logic [N*TW-1:0]   b_left;
  logic [N*TW-1:0]   b_right;
  logic              busy;
  logic              done;
`ifdef CMP_CAL_SAT_FLAGS_EN
  logic [N-1:0]      sat;
`endif

  vec_t vecs [N];
  int   n_checks;
  int   n_pass;

  cmp_cal_seq dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .cmp_out (cmp_out),
    .b_left  (b_left),
    .b_right (b_right),
    .busy    (busy),
`ifdef CMP_CAL_SAT_FLAGS_EN
    .sat     (sat),
`endif
    .done    (done)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int trim_l(int k);
    return int'(b_left[k*TW +: TW]);
  endfunction

  function automatic int trim_r(int k);
    return int'(b_right[k*TW +: TW]);
  endfunction

  // Comparator plant: ones per 250-cycle window = base - slope*left + slope*right
  initial begin
    int phase;
    int tgt;
    phase   = 0;
    cmp_out = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        tgt = vecs[k].base - vecs[k].slope * trim_l(k) + vecs[k].slope * trim_r(k);
        if (tgt < 0) tgt = 0;
        if (tgt > 250) tgt = 250;
        cmp_out[k] = (phase < tgt);
      end
      phase = (phase == 249) ? 0 : phase + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic s_en, input logic s_start);
    @(negedge clk);
    en    = s_en;
    start = s_start;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    checkOutput("sweep_finished", done, 1);
  endtask

  task automatic check_table(input string tag);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("%s_ch%0d_b_left", tag, k), trim_l(k), vecs[k].exp_bl);
      checkOutput($sformatf("%s_ch%0d_b_right", tag, k), trim_r(k), vecs[k].exp_br);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    start    = 1'b0;

    // base, slope, expected left, expected right
    vecs[0] = '{125,   8, 0, 0};
    vecs[1] = '{165,   8, 4, 0};
    vecs[2] = '{145,  40, 1, 0};
    vecs[3] = '{145, -15, 0, 0};
    vecs[4] = '{ 85,   8, 0, 4};
    vecs[5] = '{200,  20, 4, 0};
    vecs[6] = '{130,   8, 0, 0};
    vecs[7] = '{ 60,  10, 0, 6};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_b_left", b_left, 0);
    checkOutput("reset_b_right", b_right, 0);
`ifdef CMP_CAL_SAT_FLAGS_EN
    checkOutput("reset_sat", sat, 0);
`endif

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Sweep A: drop en during the first evaluation of channel 2
    $display("[TB] sweep A: enable dropped in channel 2 evaluation");
    applyStimulus(1'b1, 1'b1);
    checkOutput("A_busy_after_start", busy, 1);
    repeat (1789) @(posedge clk);
    #1;
    checkOutput("A_busy_in_eval", busy, 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("A_busy_after_en_low", busy, 0);
    checkOutput("A_done_after_en_low", done, 0);
    checkOutput("A_ch0_b_left", trim_l(0), 0);
    checkOutput("A_ch1_b_left", trim_l(1), 4);
    checkOutput("A_ch1_b_right", trim_r(1), 0);
    checkOutput("A_ch2_b_left_held", trim_l(2), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("A_ch1_b_left_still_held", trim_l(1), 4);

    // Sweep B: asynchronous reset while measuring channel 3
    $display("[TB] sweep B: reset during channel 3 measurement");
    applyStimulus(1'b1, 1'b1);
    repeat (2100) @(posedge clk);
    #1;
    checkOutput("B_ch1_b_left_before_rst", trim_l(1), 4);
    rst = 1'b1;
    #1;
    checkOutput("B_busy_in_rst", busy, 0);
    checkOutput("B_done_in_rst", done, 0);
    checkOutput("B_b_left_in_rst", b_left, 0);
    checkOutput("B_b_right_in_rst", b_right, 0);
    #3;
    rst = 1'b0;

    // Sweep C: full sweep after reset, starting again from channel 0
    $display("[TB] sweep C: full calibration");
    applyStimulus(1'b1, 1'b1);
    wait_done(15000);
    checkOutput("C_busy_at_done", busy, 0);
    check_table("C");
`ifdef CMP_CAL_SAT_FLAGS_EN
    checkOutput("C_sat", sat, 0);
`endif
    repeat (5) @(posedge clk);
    #1;
    checkOutput("C_done_held", done, 1);

    // Sweep D: channel 1 comparator stuck high saturates its left trim
    $display("[TB] sweep D: channel 1 stuck high");
    vecs[1] = '{250, 0, 31, 0};
    applyStimulus(1'b1, 1'b1);
    checkOutput("D_done_cleared_by_start", done, 0);
    checkOutput("D_busy_after_start", busy, 1);
    wait_done(15000);
    check_table("D");
`ifdef CMP_CAL_SAT_FLAGS_EN
    checkOutput("D_sat", sat, 8'b0000_0010);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
